// File: rtl/mem_access_unit_if.sv
// Data-memory port between the MEM-stage access unit (master) and the memory (slave).
interface mem_access_unit_if;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_addr;
    logic [3:0]  data_mbe;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_resp;

    modport master (
        output data_read, data_write, data_addr, data_mbe, data_wdata,
        input  data_rdata, data_resp
    );

    modport slave (
        input  data_read, data_write, data_addr, data_mbe, data_wdata,
        output data_rdata, data_resp
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-port initiator: decodes size/alignment, issues one memory access
// per load/store, stalls the pipeline until the response, and latches the result.
module mem_access_unit (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic                      mem_read_in,
    input  logic                      mem_write_in,
    input  logic [2:0]                funct3_in,
    input  logic [31:0]               addr_in,
    input  logic [31:0]               store_data_in,
    mem_access_unit_if.master         mem,
    output logic [31:0]               r_data_out,
    output logic [3:0]                mem_byte_enable_out,
    output logic                      misaligned_out,
    output logic                      stall_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  off;
    logic [3:0]  mbe_c;
    logic        misaligned_c;
    logic [31:0] wdata_c;
    logic        mem_op;
    logic        issue;

    logic        read_q;
    logic        write_q;
    logic [31:0] addr_q;
    logic [3:0]  mbe_q;
    logic [31:0] wdata_q;
    logic [31:0] r_data_q;
    logic [3:0]  mbe_out_q;

    assign off    = addr_in[1:0];
    assign mem_op = req_valid & (mem_read_in | mem_write_in);
    assign issue  = (state_q == IDLE) & mem_op & ~misaligned_c;

    // Size/alignment decode; unknown funct3 on a memory op is reported as misaligned.
    always_comb begin
        mbe_c        = 4'b0000;
        misaligned_c = 1'b0;
        wdata_c      = store_data_in << {off, 3'b000};
        case (funct3_in)
            3'b000, 3'b100: mbe_c = 4'b0001 << off;
            3'b001, 3'b101: begin
                mbe_c        = 4'b0011 << off;
                misaligned_c = (off == 2'd3);
            end
            3'b010: begin
                mbe_c        = 4'b1111;
                misaligned_c = (off != 2'd0);
                wdata_c      = store_data_in;
            end
            default: misaligned_c = 1'b1;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        stall_out      = 1'b0;
        misaligned_out = 1'b0;
        case (state_q)
            IDLE: begin
                misaligned_out = mem_op & misaligned_c;
                if (issue) begin
                    stall_out = 1'b1;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                stall_out = 1'b1;
                if (mem.data_resp) state_d = DONE;
            end
            // One unstalled cycle lets the held instruction advance.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= 32'd0;
            mbe_q     <= 4'd0;
            wdata_q   <= 32'd0;
            r_data_q  <= 32'd0;
            mbe_out_q <= 4'd0;
        end else begin
            if (issue) begin
                // Read wins when both are set.
                read_q  <= mem_read_in;
                write_q <= mem_write_in & ~mem_read_in;
                addr_q  <= {addr_in[31:2], 2'b00};
                mbe_q   <= mbe_c;
                wdata_q <= wdata_c;
            end
            if (state_q == ACCESS && mem.data_resp) begin
                read_q    <= 1'b0;
                write_q   <= 1'b0;
                mbe_out_q <= mbe_q;
                if (read_q) r_data_q <= mem.data_rdata;
            end
        end
    end

    assign mem.data_read       = read_q;
    assign mem.data_write      = write_q;
    assign mem.data_addr       = addr_q;
    assign mem.data_mbe        = mbe_q;
    assign mem.data_wdata      = wdata_q;
    assign r_data_out          = r_data_q;
    assign mem_byte_enable_out = mbe_out_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: decode table plus multi-cycle sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, mem_read_in, mem_write_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in, store_data_in;
    logic [31:0] r_data_out;
    logic [3:0]  mem_byte_enable_out;
    logic        misaligned_out, stall_out;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .mem_read_in         (mem_read_in),
        .mem_write_in        (mem_write_in),
        .funct3_in           (funct3_in),
        .addr_in             (addr_in),
        .store_data_in       (store_data_in),
        .mem                 (bus),
        .r_data_out          (r_data_out),
        .mem_byte_enable_out (mem_byte_enable_out),
        .misaligned_out      (misaligned_out),
        .stall_out           (stall_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_rdata = 32'd0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic        rd, wr;
        logic        acc, mis, er, ew;
        logic [3:0]  mbe;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sd,
                                input logic [31:0] rdata, input logic rd, input logic wr,
                                input logic acc, input logic mis, input logic er, input logic ew,
                                input logic [3:0] mbe, input logic [31:0] wdata);
        vec_t v;
        v.f3 = f3; v.addr = addr; v.sd = sd; v.rdata = rdata; v.rd = rd; v.wr = wr;
        v.acc = acc; v.mis = mis; v.er = er; v.ew = ew; v.mbe = mbe; v.wdata = wdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        req_valid = 1'b1; mem_read_in = v.rd; mem_write_in = v.wr;
        funct3_in = v.f3; addr_in = v.addr; store_data_in = v.sd;
        bus.data_rdata = v.rdata;
        #1;
        chk($sformatf("v%0d_stall_issue", idx), stall_out, v.acc);
        chk($sformatf("v%0d_misaligned", idx), misaligned_out, v.mis);
        @(posedge clk); #1;
        if (v.acc) begin
            chk($sformatf("v%0d_read", idx), bus.data_read, v.er);
            chk($sformatf("v%0d_write", idx), bus.data_write, v.ew);
            chk($sformatf("v%0d_addr", idx), bus.data_addr, {v.addr[31:2], 2'b00});
            chk($sformatf("v%0d_mbe", idx), bus.data_mbe, v.mbe);
            chk($sformatf("v%0d_wdata", idx), bus.data_wdata, v.wdata);
            chk($sformatf("v%0d_stall_access", idx), stall_out, 1'b1);
            @(negedge clk);
            bus.data_resp = 1'b1;
            @(posedge clk); #1;
            bus.data_resp = 1'b0;
            req_valid = 1'b0;
            if (v.er) exp_rdata = v.rdata;
            chk($sformatf("v%0d_stall_done", idx), stall_out, 1'b0);
            chk($sformatf("v%0d_strobe_clear", idx), {bus.data_read, bus.data_write}, 2'b00);
            chk($sformatf("v%0d_r_data", idx), r_data_out, exp_rdata);
            chk($sformatf("v%0d_mbe_out", idx), mem_byte_enable_out, v.mbe);
            @(posedge clk); #1;
            chk($sformatf("v%0d_idle_stall", idx), stall_out, 1'b0);
        end else begin
            chk($sformatf("v%0d_no_read", idx), bus.data_read, 1'b0);
            chk($sformatf("v%0d_no_write", idx), bus.data_write, 1'b0);
            chk($sformatf("v%0d_no_stall", idx), stall_out, 1'b0);
            req_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stall_cnt;
        int rises;
        logic prev;

        //      f3      addr          sd            rdata         rd wr acc mis er ew mbe      wdata
        vecs[0]  = mk(3'b000, 32'h0000_2003, 32'h0000_00A5, 32'h0,        0, 1, 1, 0, 0, 1, 4'b1000, 32'hA500_0000);
        vecs[1]  = mk(3'b001, 32'h0000_3000, 32'h0000_1234, 32'h0,        0, 1, 1, 0, 0, 1, 4'b0011, 32'h0000_1234);
        vecs[2]  = mk(3'b001, 32'h0000_3001, 32'h0000_1234, 32'h0,        0, 1, 1, 0, 0, 1, 4'b0110, 32'h0012_3400);
        vecs[3]  = mk(3'b001, 32'h0000_3002, 32'h0000_1234, 32'h0,        0, 1, 1, 0, 0, 1, 4'b1100, 32'h1234_0000);
        vecs[4]  = mk(3'b000, 32'h0000_4001, 32'h0000_0000, 32'hCAFE_F00D, 1, 0, 1, 0, 1, 0, 4'b0010, 32'h0000_0000);
        vecs[5]  = mk(3'b100, 32'h0000_4002, 32'h0000_0000, 32'h0102_0304, 1, 0, 1, 0, 1, 0, 4'b0100, 32'h0000_0000);
        vecs[6]  = mk(3'b101, 32'h0000_4006, 32'h0000_0000, 32'h55AA_55AA, 1, 0, 1, 0, 1, 0, 4'b1100, 32'h0000_0000);
        vecs[7]  = mk(3'b001, 32'h0000_4003, 32'h0000_0000, 32'h0,        1, 0, 0, 1, 0, 0, 4'b0000, 32'h0);
        vecs[8]  = mk(3'b010, 32'h0000_4002, 32'h0000_0000, 32'h0,        1, 0, 0, 1, 0, 0, 4'b0000, 32'h0);
        vecs[9]  = mk(3'b011, 32'h0000_5000, 32'h0000_0000, 32'h0,        1, 0, 0, 1, 0, 0, 4'b0000, 32'h0);
        vecs[10] = mk(3'b010, 32'h0000_6008, 32'h89AB_CDEF, 32'h0,        0, 1, 1, 0, 0, 1, 4'b1111, 32'h89AB_CDEF);
        vecs[11] = mk(3'b010, 32'h0000_7000, 32'h0000_0000, 32'h0BAD_F00D, 1, 1, 1, 0, 1, 0, 4'b1111, 32'h0000_0000);
        vecs[12] = mk(3'b000, 32'h0000_7001, 32'h0000_0000, 32'h0,        0, 0, 0, 0, 0, 0, 4'b0000, 32'h0);

        rst = 1'b1; req_valid = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        funct3_in = 3'b000; addr_in = 32'd0; store_data_in = 32'd0;
        bus.data_rdata = 32'd0; bus.data_resp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read", bus.data_read, 1'b0);
        chk("rst_write", bus.data_write, 1'b0);
        chk("rst_addr", bus.data_addr, 32'd0);
        chk("rst_mbe", bus.data_mbe, 4'd0);
        chk("rst_wdata", bus.data_wdata, 32'd0);
        chk("rst_r_data", r_data_out, 32'd0);
        chk("rst_mbe_out", mem_byte_enable_out, 4'd0);
        chk("rst_stall", stall_out, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // lw with response two cycles after issue
        @(negedge clk);
        req_valid = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
        funct3_in = 3'b010; addr_in = 32'h0000_1004; store_data_in = 32'd0;
        stall_cnt = 0;
        #1; if (stall_out) stall_cnt++;
        @(posedge clk); #1;
        if (stall_out) stall_cnt++;
        chk("lw_read", bus.data_read, 1'b1);
        chk("lw_addr", bus.data_addr, 32'h0000_1004);
        chk("lw_mbe", bus.data_mbe, 4'b1111);
        @(posedge clk); #1;
        if (stall_out) stall_cnt++;
        chk("lw_wait_read", bus.data_read, 1'b1);
        @(negedge clk);
        bus.data_resp = 1'b1; bus.data_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.data_rdata = 32'h1111_2222;
        req_valid = 1'b0;
        exp_rdata = 32'hDEAD_BEEF;
        chk("lw_stall_cycles", stall_cnt, 3);
        chk("lw_done_stall", stall_out, 1'b0);
        chk("lw_r_data", r_data_out, 32'hDEAD_BEEF);
        chk("lw_mbe_out", mem_byte_enable_out, 4'b1111);
        chk("lw_done_read", bus.data_read, 1'b0);
        @(posedge clk); #1;
        chk("resp_in_done_ignored", r_data_out, 32'hDEAD_BEEF);
        chk("lw_idle_read", bus.data_read, 1'b0);
        @(posedge clk); #1;
        chk("resp_in_idle_ignored", r_data_out, 32'hDEAD_BEEF);
        bus.data_resp = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // non-memory op followed directly by a load
        @(negedge clk);
        req_valid = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b0;
        funct3_in = 3'b000; addr_in = 32'h0000_0040;
        #1;
        chk("add_stall", stall_out, 1'b0);
        @(posedge clk); #1;
        chk("add_no_read", bus.data_read, 1'b0);
        prev = bus.data_read;
        rises = 0;
        @(negedge clk);
        mem_read_in = 1'b1; funct3_in = 3'b010; addr_in = 32'h0000_8000;
        bus.data_rdata = 32'h1357_2468;
        #1;
        chk("b2b_lw_stall", stall_out, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.data_read && !prev) rises++;
            prev = bus.data_read;
            if (i == 0) bus.data_resp = 1'b1;
            if (i == 1) begin
                bus.data_resp = 1'b0;
                req_valid = 1'b0;
                exp_rdata = 32'h1357_2468;
            end
        end
        chk("b2b_single_strobe", rises, 1);
        chk("b2b_r_data", r_data_out, exp_rdata);

        // reset during ACCESS, then a stale response
        @(negedge clk);
        req_valid = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
        funct3_in = 3'b010; addr_in = 32'h0000_9004;
        @(posedge clk); #1;
        chk("rst_mid_read_before", bus.data_read, 1'b1);
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_read", bus.data_read, 1'b0);
        chk("rst_mid_addr", bus.data_addr, 32'd0);
        chk("rst_mid_mbe", bus.data_mbe, 4'd0);
        chk("rst_mid_r_data", r_data_out, 32'd0);
        chk("rst_mid_mbe_out", mem_byte_enable_out, 4'd0);
        chk("rst_mid_stall", stall_out, 1'b0);
        @(negedge clk);
        rst = 1'b0; bus.data_resp = 1'b1; bus.data_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        chk("stale_resp_r_data", r_data_out, 32'd0);
        chk("stale_resp_mbe_out", mem_byte_enable_out, 4'd0);
        chk("stale_resp_stall", stall_out, 1'b0);
        chk("stale_resp_read", bus.data_read, 1'b0);
        bus.data_resp = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage data-port initiator for the pipelined RV32I core.
- Decodes load/store size from funct3 and the address low bits into a byte-enable mask. Aligns store data, drives the data-memory port and stalls the pipeline until the memory responds.
- Returns the raw 32-bit read word and the byte mask that the write-back stage uses to extract and extend the loaded byte, half or word.

Parameters:
- none

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  MEM stage holds a valid instruction; held stable while stall_out=1
- mem_read_in  in  1  instruction is a load
- mem_write_in  in  1  instruction is a store
- funct3_in  in  3  RV32I load/store funct3
- addr_in  in  32  effective byte address (ALU result)
- store_data_in  in  32  rs2 value
- data_rdata  in  32  memory read word
- data_resp  in  1  memory completion strobe, one cycle
- data_read  out  1  memory read request
- data_write  out  1  memory write request
- data_addr  out  32  word-aligned address
- data_mbe  out  4  memory byte enables
- data_wdata  out  32  lane-aligned store data
- r_data_out  out  32  latched read word to write-back
- mem_byte_enable_out  out  4  latched byte mask to write-back
- misaligned_out  out  1  current request is misaligned
- stall_out  out  1  freeze upstream pipeline

Behaviour:
- Byte-enable mask, combinational, with off = addr_in[1:0]:
  - byte (funct3 000/100): 0001<<off.
  - half (001/101): 0011<<off; off=3 is misaligned.
  - word (010): 1111; off!=0 is misaligned.
  - Any other funct3 with mem_read_in or mem_write_in set is treated as misaligned.
- Store data: byte = store_data_in<<(8*off); half = store_data_in<<(8*off); word unshifted.
- data_addr = {addr_in[31:2],2'b00}, registered at issue.
- mem_op = req_valid & (mem_read_in | mem_write_in).
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: if mem_op & !misaligned: register addr, mbe, wdata; set data_read=mem_read_in, data_write=mem_write_in; go to ACCESS. stall_out=1 this cycle (combinational).
  - IDLE: if mem_op & misaligned: misaligned_out=1 combinationally, no access, no stall, stay in IDLE.
  - IDLE: non-memory instruction passes with no stall.
  - ACCESS: stall_out=1; strobes and address/mbe/wdata held constant.
  - ACCESS on data_resp: clear strobes at the edge. For a load, latch data_rdata into r_data_out. For a load or store, latch the mask into mem_byte_enable_out. Go to DONE.
  - DONE: stall_out=0 for exactly one cycle so the held instruction advances; req_valid ignored; go to IDLE.
- Minimum memory-instruction latency is 3 cycles (IDLE, ACCESS, DONE) with a same-cycle-as-ACCESS resp. Each extra wait cycle adds one.
- data_resp in IDLE or DONE is ignored.
- mem_read_in and mem_write_in both set: treat as a load.
- r_data_out holds its value across stores and non-memory instructions.
- Reset values, in any state including mid-ACCESS: state=IDLE; data_read, data_write, data_addr, data_mbe, data_wdata, r_data_out, mem_byte_enable_out all 0. An outstanding resp after reset is ignored.
- The unit never issues two requests for one instruction.

Test Plan:
- lw addr 0x0000_1004, resp 2 cycles after issue, rdata 0xDEAD_BEEF -> data_read=1, data_addr=0x1004, data_mbe=1111. stall_out high for 3 cycles. r_data_out=0xDEADBEEF, mem_byte_enable_out=1111. DONE lasts one cycle.
- sb addr 0x...03, rs2=0x0000_00A5 -> data_write=1, data_mbe=1000, data_wdata=0xA500_0000; r_data_out unchanged.
- sh at offsets 0,1,2 with rs2=0x1234 -> mbe 0011/0110/1100; wdata 0x0000_1234/0x0012_3400/0x1234_0000.
- lh addr off=3 and lw addr off=2 -> misaligned_out=1, no strobes, stall_out=0.
- ADD (no mem op) back-to-back with lw -> ADD: no stall; lw: strobe asserted exactly once.
- rst asserted mid-ACCESS then data_resp -> strobes 0 after the edge, state IDLE, r_data_out=0, resp ignored.
